// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NUM_M Avalon-MM masters shared access to one memory port.
// Read data returns in order and is routed back through a FIFO of owner tags.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_M      = 3,
    parameter int MAX_PEND   = 4,
    parameter int MAX_HOLD   = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_M*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_M*BE_WIDTH-1:0]   m_byteenable,
    input  logic [NUM_M-1:0]            m_read,
    input  logic [NUM_M-1:0]            m_write,
    input  logic [NUM_M*DATA_WIDTH-1:0] m_writedata,
    output logic [NUM_M-1:0]            m_waitrequest,
    output logic [DATA_WIDTH-1:0]       m_readdata,
    output logic [NUM_M-1:0]            m_readdataready,
    output logic [ADDR_WIDTH-1:0]       s_address,
    output logic [BE_WIDTH-1:0]         s_byteenable,
    output logic                        s_read,
    output logic                        s_write,
    output logic [DATA_WIDTH-1:0]       s_writedata,
    input  logic [DATA_WIDTH-1:0]       s_readdata,
    input  logic                        s_readdataready,
    input  logic                        s_waitrequest,
    output logic [NUM_M-1:0]            grant,
    output logic                        err_unexpected
);
    localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CNT_W  = $clog2(MAX_PEND + 1);
    localparam int PTR_W  = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state_q, state_d;
    logic [NUM_M-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  tag_mem [MAX_PEND];

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_M];
    logic [BE_WIDTH-1:0]   be_arr    [NUM_M];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_M];
    logic [NUM_M-1:0]      req;

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign be_arr[gi]    = m_byteenable[gi*BE_WIDTH +: BE_WIDTH];
            assign wdata_arr[gi] = m_writedata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req[gi]       = m_read[gi] | m_write[gi];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_PEND - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Round-robin scan starting just after the last owner.
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   scan;

    always_comb begin : arbitrate
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            scan = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(NUM_M))
                scan = scan - (IDX_W+1)'(NUM_M);
            if (!win_found && req[scan[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IDX_W-1:0];
            end
        end
    end

    logic in_owned, own_read, own_write, own_req;
    logic fifo_full, room, pop, push, accepted;

    always_comb begin : datapath
        in_owned  = (state_q == OWNED);
        own_read  = in_owned & m_read[owner_q];
        own_write = in_owned & m_write[owner_q];
        own_req   = own_read | own_write;
        fifo_full = (count_q == CNT_W'(MAX_PEND));
        pop       = s_readdataready & (count_q != '0);
        // A slot freed by a same-cycle pop is usable at once, so a full FIFO
        // under steady return traffic keeps streaming.
        room      = !fifo_full | pop;

        s_address    = addr_arr[owner_q];
        s_byteenable = be_arr[owner_q];
        s_writedata  = wdata_arr[owner_q];
        s_write      = own_write;
        s_read       = own_read & room & !own_write;

        accepted = (s_read | s_write) & !s_waitrequest;
        push     = s_read & !s_waitrequest;

        m_waitrequest = '1;
        if (in_owned)
            m_waitrequest[owner_q] = s_waitrequest | (own_read & !room);

        m_readdata      = s_readdata;
        m_readdataready = '0;
        if (pop)
            m_readdataready[tag_mem[rd_ptr_q]] = 1'b1;
    end

    logic [HOLD_W-1:0] hold_inc;
    logic              other_req, stalled;

    always_comb begin : next_state
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        other_req  = |(req & ~grant_q);
        stalled    = own_req & !accepted;
        hold_inc   = hold_cnt_q;
        if (accepted && hold_cnt_q != HOLD_W'(MAX_HOLD))
            hold_inc = hold_cnt_q + HOLD_W'(1);

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = OWNED;
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    hold_cnt_d       = '0;
                end
            end
            OWNED: begin
                hold_cnt_d = hold_inc;
                // Never let go mid-transfer: the memory side would see the
                // command change under waitrequest.
                if (!stalled && (!own_req ||
                        (hold_inc == HOLD_W'(MAX_HOLD) && other_req))) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    rr_ptr_d   = owner_q;
                    hold_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
        err_d = err_q | (s_readdataready & (count_q == '0));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= IDX_W'(NUM_M - 1);
            hold_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            tag_mem[wr_ptr_q] <= owner_q;
    end

    assign grant          = grant_q;
    assign err_unexpected = err_q;

endmodule
